// File: rtl/io_bus_ctrl_if.sv
// io_bus_ctrl_if: requester handshake and I/O bus control signals for io_bus_ctrl.
// Port-indexed vectors carry the two requesters: index 0 = CPU, index 1 = DMA.
// The tri-stated DATA bus is not carried here; it is a plain inout on the controller.
`timescale 1ns/1ps
interface io_bus_ctrl_if;
   // Requester side
   logic [1:0]       REQ_VALID;
   logic [1:0]       REQ_WE;
   logic [1:0][19:0] REQ_ADDR;
   logic [1:0][7:0]  REQ_WDATA;
   logic [1:0]       REQ_IOM;
   logic [1:0]       REQ_READY;
   logic [1:0]       RSP_VALID;
   logic [1:0][7:0]  RSP_RDATA;
   logic [1:0]       RSP_ERR;

   // Bus side
   logic             ALE;
   logic             RD;
   logic             WR;
   logic             IOM;
   logic [19:0]      ADDRESS;
   logic [1:0]       CS;
   logic             DATA_OE;   // controller is driving DATA (transceiver direction)
   logic             BUSY;

   // Bus master: the controller itself
   modport master (
      input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_IOM,
      output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
      output ALE, RD, WR, IOM, ADDRESS, CS, DATA_OE, BUSY
   );

   // Requesters and devices
   modport slave (
      output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_IOM,
      input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
      input  ALE, RD, WR, IOM, ADDRESS, CS, DATA_OE, BUSY
   );
endinterface

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: two-port round-robin master running 8088-style T1..T4 I/O cycles
// toward two 16-byte register windows. Unmapped addresses get a one-cycle error
// response without touching the bus. All bus and response outputs are registered;
// only REQ_READY is combinational so a grant lands in the same cycle it is seen.
`timescale 1ns/1ps
module io_bus_ctrl #(
   parameter logic [19:0] BASE0 = 20'h0FF00,
   parameter logic [19:0] BASE1 = 20'h0FF10
) (
   input  logic          CLK,
   input  logic          RESET,
   inout  wire  [7:0]    DATA,
   io_bus_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_T4   = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   // Window decode; bases need not be 16-byte aligned.
   function automatic logic [1:0] decode_cs(input logic [19:0] addr);
      logic [1:0] cs;
      if ((addr >= BASE0) && (addr <= (BASE0 + 20'd15))) begin
         cs = 2'b01;
      end else if ((addr >= BASE1) && (addr <= (BASE1 + 20'd15))) begin
         cs = 2'b10;
      end else begin
         cs = 2'b00;
      end
      return cs;
   endfunction

   state_t      state_q;
   logic        prio_q;       // port that wins a tie
   logic        owner_q;      // port owning the transaction in flight
   logic        we_q;
   logic [7:0]  wdata_q;
   logic        ale_q;
   logic        rd_q;
   logic        wr_q;
   logic        iom_q;
   logic [19:0] address_q;
   logic [1:0]  cs_q;
   logic        data_oe_q;
   logic [7:0]  data_out_q;
   logic        busy_q;
   logic [1:0]  rsp_valid_q;
   logic [1:0]  rsp_err_q;
   logic [7:0]  rsp_rdata_q;

   logic        accept_ok_d;
   logic [1:0]  gnt_d;
   logic        sel_port_d;
   logic        sel_we_d;
   logic [19:0] sel_addr_d;
   logic [7:0]  sel_wdata_d;
   logic        sel_iom_d;
   logic [1:0]  sel_cs_d;

   // Round-robin grant and selection of the winning request fields
   always_comb begin
      accept_ok_d = (state_q == S_IDLE) || (state_q == S_T4);
      gnt_d       = 2'b00;
      if (accept_ok_d && !RESET) begin
         if (bus.REQ_VALID[0] && (!bus.REQ_VALID[1] || (prio_q == 1'b0))) begin
            gnt_d = 2'b01;
         end else if (bus.REQ_VALID[1]) begin
            gnt_d = 2'b10;
         end else begin
            gnt_d = 2'b00;
         end
      end else begin
         gnt_d = 2'b00;
      end
      sel_port_d  = gnt_d[1];
      sel_we_d    = bus.REQ_WE[sel_port_d];
      sel_addr_d  = bus.REQ_ADDR[sel_port_d];
      sel_wdata_d = bus.REQ_WDATA[sel_port_d];
      sel_iom_d   = bus.REQ_IOM[sel_port_d];
      sel_cs_d    = decode_cs(sel_addr_d);
   end

   // Bus-cycle sequencer; every output register is loaded with its value for the next state
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         prio_q      <= 1'b0;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         wdata_q     <= 8'h00;
         ale_q       <= 1'b0;
         rd_q        <= 1'b1;
         wr_q        <= 1'b1;
         iom_q       <= 1'b0;
         address_q   <= 20'h00000;
         cs_q        <= 2'b00;
         data_oe_q   <= 1'b0;
         data_out_q  <= 8'h00;
         busy_q      <= 1'b0;
         rsp_valid_q <= 2'b00;
         rsp_err_q   <= 2'b00;
         rsp_rdata_q <= 8'h00;
      end else begin
         case (state_q)
            S_IDLE, S_T4: begin
               // Any response pulse from T4 lasts exactly one cycle.
               rsp_valid_q <= 2'b00;
               rsp_err_q   <= 2'b00;
               rd_q        <= 1'b1;
               wr_q        <= 1'b1;
               data_oe_q   <= 1'b0;
               if (gnt_d != 2'b00) begin
                  owner_q <= sel_port_d;
                  we_q    <= sel_we_d;
                  wdata_q <= sel_wdata_d;
                  prio_q  <= ~sel_port_d;
                  busy_q  <= 1'b1;
                  if (sel_cs_d != 2'b00) begin
                     state_q   <= S_T1;
                     ale_q     <= 1'b1;
                     address_q <= sel_addr_d;
                     iom_q     <= sel_iom_d;
                     cs_q      <= sel_cs_d;
                  end else begin
                     // Unmapped: answer immediately, bus stays quiet.
                     state_q     <= S_ERR;
                     ale_q       <= 1'b0;
                     cs_q        <= 2'b00;
                     rsp_valid_q <= sel_port_d ? 2'b10 : 2'b01;
                     rsp_err_q   <= sel_port_d ? 2'b10 : 2'b01;
                     rsp_rdata_q <= 8'hFF;
                  end
               end else begin
                  state_q <= S_IDLE;
                  ale_q   <= 1'b0;
                  cs_q    <= 2'b00;
                  busy_q  <= 1'b0;
               end
            end
            S_T1: begin
               // Strobe goes active for T2; write data driven alongside WR.
               state_q    <= S_T2;
               ale_q      <= 1'b0;
               rd_q       <= we_q;
               wr_q       <= ~we_q;
               data_oe_q  <= we_q;
               data_out_q <= wdata_q;
            end
            S_T2: begin
               state_q <= S_T3;
            end
            S_T3: begin
               // Device drives read data throughout T3; sample it on the way out.
               state_q     <= S_T4;
               rd_q        <= 1'b1;
               wr_q        <= 1'b1;
               data_oe_q   <= 1'b0;
               rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
               rsp_err_q   <= 2'b00;
               rsp_rdata_q <= we_q ? 8'h00 : DATA;
            end
            S_ERR: begin
               state_q     <= S_IDLE;
               rsp_valid_q <= 2'b00;
               rsp_err_q   <= 2'b00;
               busy_q      <= 1'b0;
            end
            default: begin
               state_q     <= S_IDLE;
               ale_q       <= 1'b0;
               rd_q        <= 1'b1;
               wr_q        <= 1'b1;
               cs_q        <= 2'b00;
               data_oe_q   <= 1'b0;
               busy_q      <= 1'b0;
               rsp_valid_q <= 2'b00;
               rsp_err_q   <= 2'b00;
            end
         endcase
      end
   end

   assign bus.REQ_READY = gnt_d;
   assign bus.RSP_VALID = rsp_valid_q;
   assign bus.RSP_ERR   = rsp_err_q;
   assign bus.RSP_RDATA = {rsp_rdata_q, rsp_rdata_q};
   assign bus.ALE       = ale_q;
   assign bus.RD        = rd_q;
   assign bus.WR        = wr_q;
   assign bus.IOM       = iom_q;
   assign bus.ADDRESS   = address_q;
   assign bus.CS        = cs_q;
   assign bus.DATA_OE   = data_oe_q;
   assign bus.BUSY      = busy_q;

   assign DATA = data_oe_q ? data_out_q : 8'hzz;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb_io_bus_ctrl: directed bench for io_bus_ctrl with a two-window register device
// model on DATA. Drivers push expected responses into per-port queues at grant;
// an independent monitor pops and compares whenever RSP_VALID pulses.
`timescale 1ns/1ps
module tb_io_bus_ctrl;

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      int         cyc;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RESET;
   wire  [7:0]  data_bus;
   io_bus_ctrl_if bus ();

   io_bus_ctrl dut (
      .CLK   (CLK),
      .RESET (RESET),
      .DATA  (data_bus),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int cycle_q = 0;
   always @(posedge CLK) cycle_q <= cycle_q + 1;

   // Requester drive
   logic        tb_valid [2];
   logic        tb_we    [2];
   logic [19:0] tb_addr  [2];
   logic [7:0]  tb_wdata [2];
   logic        tb_iom   [2];
   assign bus.REQ_VALID = {tb_valid[1], tb_valid[0]};
   assign bus.REQ_WE    = {tb_we[1], tb_we[0]};
   assign bus.REQ_ADDR  = {tb_addr[1], tb_addr[0]};
   assign bus.REQ_WDATA = {tb_wdata[1], tb_wdata[0]};
   assign bus.REQ_IOM   = {tb_iom[1], tb_iom[0]};

   // Device model: register files behind CS[0] and CS[1]
   logic       dev_load;
   logic [7:0] mem0 [16];
   logic [7:0] mem1 [16];
   wire        dev_drive = !bus.RD && (bus.CS != 2'b00);
   wire [7:0]  dev_rdata = bus.CS[0] ? mem0[bus.ADDRESS[3:0]] : mem1[bus.ADDRESS[3:0]];
   assign data_bus = dev_drive ? dev_rdata : 8'hzz;

   always @(posedge CLK) begin
      if (dev_load) begin
         mem0[3]  <= 8'hA5;
         mem0[15] <= 8'hC3;
         mem1[15] <= 8'hE7;
      end else if (!bus.WR && bus.CS == 2'b01) begin
         mem0[bus.ADDRESS[3:0]] <= data_bus;
      end else if (!bus.WR && bus.CS == 2'b10) begin
         mem1[bus.ADDRESS[3:0]] <= data_bus;
      end
   end

   // Scoreboard state
   exp_t q0 [$];
   exp_t q1 [$];
   int   grant_log [$];
   int   grant_cyc [$];
   int   cmp_cnt = 0;
   int   bad_cnt = 0;
   logic mon_en  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle_q);
      end
   endtask

   // Response monitor
   always @(negedge CLK) begin
      exp_t e;
      if (mon_en) begin
         for (int p = 0; p < 2; p++) begin
            if (bus.RSP_VALID[p]) begin
               if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
                  chk($sformatf("unexpected_rsp_p%0d", p), 32'd1, 32'd0);
               end else begin
                  e = (p == 0) ? q0.pop_front() : q1.pop_front();
                  chk($sformatf("rsp_rdata_p%0d", p), {24'd0, bus.RSP_RDATA[p]}, {24'd0, e.rdata});
                  chk($sformatf("rsp_err_p%0d", p), {31'd0, bus.RSP_ERR[p]}, {31'd0, e.err});
                  chk($sformatf("rsp_cycle_p%0d", p), cycle_q, e.cyc);
               end
            end
         end
      end
   end

   // Present one request on port p and wait (bounded) for its grant
   task automatic issue(input int p, input logic we, input logic [19:0] addr,
                        input logic [7:0] wd, input logic iom, input logic [7:0] exp_rd,
                        input logic exp_err, input int lat, input bit push, output int acc_c);
      bit   done = 1'b0;
      exp_t e;
      acc_c       = -1;
      tb_we[p]    = we;
      tb_addr[p]  = addr;
      tb_wdata[p] = wd;
      tb_iom[p]   = iom;
      tb_valid[p] = 1'b1;
      for (int k = 0; k < 64 && !done; k++) begin
         @(negedge CLK);
         if (bus.REQ_READY[p]) begin
            done  = 1'b1;
            acc_c = cycle_q;
            if (push) begin
               e.rdata = exp_rd;
               e.err   = exp_err;
               e.cyc   = cycle_q + lat;
               if (p == 0) q0.push_back(e);
               else        q1.push_back(e);
            end
            grant_log.push_back(p);
            grant_cyc.push_back(cycle_q);
         end
      end
      if (!done) chk($sformatf("grant_timeout_p%0d", p), 32'd0, 32'd1);
      @(posedge CLK); #1;
      tb_valid[p] = 1'b0;
   endtask

   // Wait (bounded) for every expected response to be seen
   task automatic drain(input string name);
      for (int k = 0; k < 40; k++) begin
         if (q0.size() == 0 && q1.size() == 0) break;
         @(negedge CLK);
      end
      chk(name, q0.size() + q1.size(), 32'd0);
      @(posedge CLK); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      for (int p = 0; p < 2; p++) begin
         tb_valid[p] = 1'b0; tb_we[p] = 1'b0; tb_addr[p] = 20'h00000;
         tb_wdata[p] = 8'h00; tb_iom[p] = 1'b0;
      end
      RESET    = 1'b1;
      dev_load = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      // Reset values
      chk("rst_ale_rd_wr_iom", {28'd0, bus.ALE, bus.RD, bus.WR, bus.IOM}, 32'h6);
      chk("rst_address", {12'd0, bus.ADDRESS}, 32'd0);
      chk("rst_cs_oe_busy", {28'd0, bus.CS, bus.DATA_OE, bus.BUSY}, 32'd0);
      chk("rst_ready_rspv_err", {26'd0, bus.REQ_READY, bus.RSP_VALID, bus.RSP_ERR}, 32'd0);
      chk("rst_rdata", {16'd0, bus.RSP_RDATA}, 32'd0);
      RESET    = 1'b0;
      dev_load = 1'b0;
      mon_en   = 1'b1;
      @(posedge CLK); #1;

      // Port 0 read of device 0, plus a port 1 request withdrawn before any grant
      issue(0, 1'b0, 20'h0FF03, 8'h00, 1'b1, 8'hA5, 1'b0, 4, 1'b1, c);
      tb_addr[1] = 20'h0FF10; tb_valid[1] = 1'b1;
      @(negedge CLK);
      chk("rd_t1_ale_rd_wr", {29'd0, bus.ALE, bus.RD, bus.WR}, 32'h7);
      chk("rd_t1_cs", {30'd0, bus.CS}, 32'h1);
      chk("rd_t1_address", {12'd0, bus.ADDRESS}, 32'h0FF03);
      chk("rd_t1_busy_oe", {30'd0, bus.BUSY, bus.DATA_OE}, 32'h2);
      chk("rd_t1_ready1", {31'd0, bus.REQ_READY[1]}, 32'd0);
      @(negedge CLK);
      chk("rd_t2_ale_rd_wr", {29'd0, bus.ALE, bus.RD, bus.WR}, 32'h1);
      chk("rd_t2_oe", {31'd0, bus.DATA_OE}, 32'd0);
      @(negedge CLK);
      chk("rd_t3_ale_rd_wr", {29'd0, bus.ALE, bus.RD, bus.WR}, 32'h1);
      chk("rd_t3_oe", {31'd0, bus.DATA_OE}, 32'd0);
      chk("rd_t3_ready1", {31'd0, bus.REQ_READY[1]}, 32'd0);
      tb_valid[1] = 1'b0;
      @(negedge CLK);
      chk("rd_t4_ale_rd_wr", {29'd0, bus.ALE, bus.RD, bus.WR}, 32'h3);
      chk("rd_t4_cs_oe", {29'd0, bus.CS, bus.DATA_OE}, 32'h2);
      chk("rd_t4_ready1", {31'd0, bus.REQ_READY[1]}, 32'd0);
      drain("drain_rd0");
      chk("idle_cs_oe_busy", {28'd0, bus.CS, bus.DATA_OE, bus.BUSY}, 32'd0);

      // Port 1 write to device 1
      issue(1, 1'b1, 20'h0FF1A, 8'h3C, 1'b1, 8'h00, 1'b0, 4, 1'b1, c);
      @(negedge CLK);
      chk("wr_t1_ale_cs_iom", {28'd0, bus.ALE, bus.CS, bus.IOM}, 32'h5 | 32'h8);
      @(negedge CLK);
      chk("wr_t2_rd_wr_oe", {29'd0, bus.RD, bus.WR, bus.DATA_OE}, 32'h5);
      chk("wr_t2_data", {24'd0, data_bus}, 32'h3C);
      @(negedge CLK);
      chk("wr_t3_rd_wr_oe", {29'd0, bus.RD, bus.WR, bus.DATA_OE}, 32'h5);
      chk("wr_t3_data", {24'd0, data_bus}, 32'h3C);
      @(negedge CLK);
      chk("wr_t4_rd_wr_oe", {29'd0, bus.RD, bus.WR, bus.DATA_OE}, 32'h6);
      drain("drain_wr1");

      // Read-back of the written byte
      issue(1, 1'b0, 20'h0FF1A, 8'h00, 1'b0, 8'h3C, 1'b0, 4, 1'b1, c);
      drain("drain_rb1");

      // Both ports continuously valid: alternate grants, back-to-back T4->T1
      grant_log.delete();
      grant_cyc.delete();
      fork
         begin
            issue(0, 1'b0, 20'h0FF03, 8'h00, 1'b0, 8'hA5, 1'b0, 4, 1'b1, c);
            issue(0, 1'b0, 20'h0FF0F, 8'h00, 1'b0, 8'hC3, 1'b0, 4, 1'b1, c);
         end
         begin
            issue(1, 1'b1, 20'h0FF10, 8'h11, 1'b0, 8'h00, 1'b0, 4, 1'b1, c);
            issue(1, 1'b0, 20'h0FF1A, 8'h00, 1'b0, 8'h3C, 1'b0, 4, 1'b1, c);
         end
      join
      drain("drain_rr");
      chk("rr_count", grant_log.size(), 32'd4);
      if (grant_log.size() == 4) begin
         chk("rr_order", {grant_log[0][7:0], grant_log[1][7:0], grant_log[2][7:0], grant_log[3][7:0]},
             32'h00010001);
         for (int i = 0; i < 3; i++)
            chk($sformatf("rr_spacing_%0d", i), grant_cyc[i + 1] - grant_cyc[i], 32'd4);
      end

      // Unmapped addresses and window edges
      issue(0, 1'b0, 20'h12345, 8'h00, 1'b0, 8'hFF, 1'b1, 1, 1'b1, c);
      @(negedge CLK);
      chk("err_ale_rd_wr", {29'd0, bus.ALE, bus.RD, bus.WR}, 32'h3);
      chk("err_cs_busy", {29'd0, bus.CS, bus.BUSY}, 32'h1);
      @(negedge CLK);
      chk("err_idle_busy", {31'd0, bus.BUSY}, 32'd0);
      @(posedge CLK); #1;
      issue(1, 1'b1, 20'h0FF20, 8'h55, 1'b0, 8'hFF, 1'b1, 1, 1'b1, c);
      issue(0, 1'b0, 20'h0FEFF, 8'h00, 1'b0, 8'hFF, 1'b1, 1, 1'b1, c);
      issue(1, 1'b0, 20'h0FF1F, 8'h00, 1'b0, 8'hE7, 1'b0, 4, 1'b1, c);
      drain("drain_edges");

      // RESET during T3 of a write: transaction dropped, bus released
      issue(0, 1'b1, 20'h0FF05, 8'h99, 1'b0, 8'h00, 1'b0, 4, 1'b0, c);
      @(negedge CLK);
      @(negedge CLK);
      @(negedge CLK);
      chk("rst_pre_t3_wr_oe", {30'd0, bus.WR, bus.DATA_OE}, 32'h1);
      RESET = 1'b1;
      @(negedge CLK);
      chk("rst_mid_rd_wr_ale", {29'd0, bus.RD, bus.WR, bus.ALE}, 32'h6);
      chk("rst_mid_cs_oe_busy", {28'd0, bus.CS, bus.DATA_OE, bus.BUSY}, 32'd0);
      chk("rst_mid_rsp", {28'd0, bus.RSP_VALID, bus.RSP_ERR}, 32'd0);
      chk("rst_mid_address", {12'd0, bus.ADDRESS}, 32'd0);
      RESET = 1'b0;
      @(posedge CLK); #1;

      // Fresh tie after reset goes to port 0, then port 1
      grant_log.delete();
      grant_cyc.delete();
      fork
         issue(0, 1'b0, 20'h0FF03, 8'h00, 1'b0, 8'hA5, 1'b0, 4, 1'b1, c);
         issue(1, 1'b0, 20'h0FF1A, 8'h00, 1'b0, 8'h3C, 1'b0, 4, 1'b1, c);
      join
      drain("drain_post_rst");
      chk("post_rst_order", grant_log.size() == 2 ? {grant_log[0][15:0], grant_log[1][15:0]} : 32'hFFFF_FFFF,
          32'h00000001);

      repeat (4) @(posedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
      $finish;
   end

endmodule
